// File: rtl/mulpop_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mulpop_arbiter_if
// Brief    : Requester, response and datapath signal bundle for the
//            two-requester multiply/ones-count arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mulpop_arbiter_if #(
    parameter int OPW   = 24,
    parameter int RESW  = 32,
    parameter int ONESW = 6
);
    // Requester side
    logic             req0;
    logic             req1;
    logic [OPW-1:0]   a1_0;
    logic [OPW-1:0]   a1_1;
    logic [OPW-1:0]   a2_0;
    logic [OPW-1:0]   a2_1;
    logic             ack0;
    logic             ack1;
    logic [RESW-1:0]  rsp_result;
    logic [ONESW-1:0] rsp_ones;
    logic [1:0]       rsp_status;

    // Datapath side
    logic             dp_start;
    logic [OPW-1:0]   dp_a1;
    logic [OPW-1:0]   dp_a2;
    logic             dp_done;
    logic [RESW-1:0]  dp_result;
    logic             dp_valid;
    logic [ONESW-1:0] dp_ones;
    logic             dp_abort;

    // Arbiter view
    modport slave (
        input  req0, req1, a1_0, a1_1, a2_0, a2_1,
        input  dp_done, dp_result, dp_valid, dp_ones,
        output ack0, ack1, rsp_result, rsp_ones, rsp_status,
        output dp_start, dp_a1, dp_a2, dp_abort
    );

    // Environment view (requesters + datapath)
    modport master (
        output req0, req1, a1_0, a1_1, a2_0, a2_1,
        output dp_done, dp_result, dp_valid, dp_ones,
        input  ack0, ack1, rsp_result, rsp_ones, rsp_status,
        input  dp_start, dp_a1, dp_a2, dp_abort
    );
endinterface
`default_nettype wire

// File: rtl/mulpop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mulpop_arbiter
// Brief    : Round-robin scheduler placing jobs from two requesters onto a
//            shared multiply + ones-count datapath, with timeout abort and a
//            16-bit completed-job counter.
// Revision : 1.0 - initial release
// ============================================================================
module mulpop_arbiter #(
    parameter int OPW     = 24,
    parameter int RESW    = 32,
    parameter int ONESW   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            n_reset,
    mulpop_arbiter_if.slave bus,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]       ST_OK    = 2'b11;
    localparam logic [1:0]       ST_OVF   = 2'b10;
    localparam logic [1:0]       ST_TMO   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_grant;        // 0 = requester 0 owns the current job
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [OPW-1:0]   r_dp_a1;
    logic [OPW-1:0]   r_dp_a2;
    logic             r_dp_start;
    logic             r_dp_abort;
    logic             r_ack0;
    logic             r_ack1;
    logic [RESW-1:0]  r_rsp_result;
    logic [ONESW-1:0] r_rsp_ones;
    logic [1:0]       r_rsp_status;
    logic [15:0]      r_op_count;
    logic             w_pick;

    // Requester selection: a lone request wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        w_pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            w_pick = ~r_last_grant;
        end
    end

    // Job sequencer; every output is registered so pulses are glitch-free
    // and land in the cycle of the state they belong to.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_tmo_cnt    <= '0;
            r_dp_a1      <= '0;
            r_dp_a2      <= '0;
            r_dp_start   <= 1'b0;
            r_dp_abort   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ones   <= '0;
            r_rsp_status <= 2'b00;
            r_op_count   <= 16'd0;
        end else begin
            // Single-cycle pulses fall back to 0 unless re-armed below
            r_dp_start <= 1'b0;
            r_dp_abort <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_dp_a1      <= w_pick ? bus.a1_1 : bus.a1_0;
                        r_dp_a2      <= w_pick ? bus.a2_1 : bus.a2_0;
                        // Armed here so the pulse is visible during ISSUE
                        r_dp_start   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion is tested first so a done in the last
                    // allowed cycle still counts as a finished job.
                    if (bus.dp_done) begin
                        r_rsp_result <= bus.dp_result;
                        r_rsp_ones   <= bus.dp_ones;
                        r_rsp_status <= bus.dp_valid ? ST_OK : ST_OVF;
                        r_op_count   <= r_op_count + 16'd1;
                        r_ack0       <= ~r_grant;
                        r_ack1       <= r_grant;
                        r_state      <= S_RESP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_rsp_result <= '0;
                        r_rsp_ones   <= '0;
                        r_rsp_status <= ST_TMO;
                        r_dp_abort   <= 1'b1;
                        r_ack0       <= ~r_grant;
                        r_ack1       <= r_grant;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dp_start   = r_dp_start;
    assign bus.dp_abort   = r_dp_abort;
    assign bus.dp_a1      = r_dp_a1;
    assign bus.dp_a2      = r_dp_a2;
    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_ones   = r_rsp_ones;
    assign bus.rsp_status = r_rsp_status;
    assign busy           = (r_state != S_IDLE);
    assign op_count       = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_mulpop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mulpop_arbiter
// Brief    : Directed self-checking bench for mulpop_arbiter with a
//            programmable-latency datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mulpop_arbiter;

    logic        clk;
    logic        n_reset;
    logic        busy;
    logic [15:0] op_count;

    mulpop_arbiter_if #(.OPW(24), .RESW(32), .ONESW(6)) bus ();

    mulpop_arbiter #(
        .OPW     (24),
        .RESW    (32),
        .ONESW   (6),
        .TIMEOUT (64)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Cycle bookkeeping filled in by the monitor
    int cyc     = 0;
    int n_start = 0;
    int n_ack0  = 0;
    int n_ack1  = 0;
    int n_abort = 0;
    int t_req   = 0;
    int t_start = 0;
    int t_ack   = 0;
    int t_abort = 0;
    int grants[$];
    logic [23:0] start_a1[$];

    // Datapath model controls
    int          m_delay = 3;
    bit          m_never = 0;
    int          m_cnt   = 0;
    logic [31:0] m_result = '0;
    logic [5:0]  m_ones   = '0;
    logic        m_valid  = 1'b1;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: records pulses and their cycle numbers
    initial begin
        forever begin
            @(negedge clk);
            if (bus.dp_start) begin
                n_start = n_start + 1;
                t_start = cyc;
                start_a1.push_back(bus.dp_a1);
            end
            if (bus.ack0) begin
                n_ack0 = n_ack0 + 1;
                t_ack  = cyc;
                grants.push_back(0);
            end
            if (bus.ack1) begin
                n_ack1 = n_ack1 + 1;
                t_ack  = cyc;
                grants.push_back(1);
            end
            if (bus.dp_abort) begin
                n_abort = n_abort + 1;
                t_abort = cyc;
            end
        end
    end

    // Datapath model: dp_done appears m_delay cycles after the dp_start cycle
    initial begin
        bus.dp_done   = 1'b0;
        bus.dp_result = '0;
        bus.dp_valid  = 1'b0;
        bus.dp_ones   = '0;
        forever begin
            @(negedge clk);
            bus.dp_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    bus.dp_done   = 1'b1;
                    bus.dp_result = m_result;
                    bus.dp_valid  = m_valid;
                    bus.dp_ones   = m_ones;
                end
            end
            if (bus.dp_start && !m_never) begin
                m_cnt = m_delay;
            end
        end
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, test did not complete");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_model(input int delay, input bit never, input logic [31:0] res,
                             input logic [5:0] ones, input logic valid);
        m_delay  = delay;
        m_never  = never;
        m_result = res;
        m_ones   = ones;
        m_valid  = valid;
    endtask

    // One job from one requester; returns once ack is seen or the budget runs out
    task automatic run_job(input bit who, input logic [23:0] a1, input logic [23:0] a2,
                           input int budget, output bit seen);
        @(negedge clk);
        if (who) begin
            bus.a1_1 = a1;
            bus.a2_1 = a2;
            bus.req1 = 1'b1;
        end else begin
            bus.a1_0 = a1;
            bus.a2_0 = a2;
            bus.req0 = 1'b1;
        end
        t_req = cyc;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) seen = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},     {31'd0, busy},           32'd0);
        check({pfx, "_opcnt"},    {16'd0, op_count},       32'd0);
        check({pfx, "_acks"},     {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check({pfx, "_pulses"},   {30'd0, bus.dp_start, bus.dp_abort}, 32'd0);
        check({pfx, "_result"},   bus.rsp_result,          32'd0);
        check({pfx, "_ones_st"},  {24'd0, bus.rsp_ones, bus.rsp_status}, 32'd0);
        check({pfx, "_dp_a1"},    {8'd0, bus.dp_a1},       32'd0);
        check({pfx, "_dp_a2"},    {8'd0, bus.dp_a2},       32'd0);
    endtask

    initial begin
        bit seen;
        int b_ack0, b_ack1, b_start, b_abort, acks;

        n_reset  = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a1_0 = '0;
        bus.a2_0 = '0;
        bus.a1_1 = '0;
        bus.a2_1 = '0;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- 1: single job, 3 x 5 ----------------
        set_model(3, 0, 32'd15, 6'd4, 1'b1);
        b_ack0 = n_ack0; b_ack1 = n_ack1; b_start = n_start; b_abort = n_abort;
        run_job(0, 24'd3, 24'd5, 50, seen);
        check("t1_ack_seen",   {31'd0, seen},             32'd1);
        check("t1_ack0_cnt",   n_ack0 - b_ack0,           32'd1);
        check("t1_ack1_cnt",   n_ack1 - b_ack1,           32'd0);
        check("t1_starts",     n_start - b_start,         32'd1);
        check("t1_start_lat",  t_start - t_req,           32'd1);
        check("t1_ack_lat",    t_ack - t_start,           32'd4);
        check("t1_result",     bus.rsp_result,            32'd15);
        check("t1_ones",       {26'd0, bus.rsp_ones},     32'd4);
        check("t1_status",     {30'd0, bus.rsp_status},   32'd3);
        check("t1_opcnt",      {16'd0, op_count},         32'd1);
        check("t1_dp_a1",      {8'd0, bus.dp_a1},         32'd3);
        check("t1_dp_a2",      {8'd0, bus.dp_a2},         32'd5);
        check("t1_busy_resp",  {31'd0, busy},             32'd1);
        repeat (3) @(negedge clk);
        check("t1_busy_after", {31'd0, busy},             32'd0);
        check("t1_ack0_once",  n_ack0 - b_ack0,           32'd1);
        check("t1_no_abort",   n_abort - b_abort,         32'd0);

        // ---------------- 2: both requesting from reset ----------------
        @(negedge clk);
        n_reset = 1'b0;
        grants.delete();
        start_a1.delete();
        set_model(2, 0, 32'h7, 6'd3, 1'b1);
        bus.a1_0 = 24'h000011;
        bus.a2_0 = 24'h000022;
        bus.a1_1 = 24'h123456;
        bus.a2_1 = 24'h000002;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        b_start = n_start;
        @(negedge clk);
        n_reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) acks = acks + 1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check("t2_acks",     acks,              32'd4);
        check("t2_ngrants",  grants.size(),     32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_grant%0d", k),
                  (k < grants.size()) ? grants[k] : 32'hF, (k % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("t2_start_a1_%0d", k),
                  (k < start_a1.size()) ? {8'd0, start_a1[k]} : 32'hFFFF_FFFF,
                  (k % 2 == 0) ? 32'h000011 : 32'h123456);
        end
        repeat (4) @(negedge clk);
        check("t2_starts",   n_start - b_start, 32'd4);
        check("t2_opcnt",    {16'd0, op_count}, 32'd4);
        check("t2_dp_a1",    {8'd0, bus.dp_a1}, 32'h123456);

        // ---------------- 3: overflow ----------------
        set_model(2, 0, 32'h0000_0001, 6'd1, 1'b0);
        b_ack1 = n_ack1;
        run_job(1, 24'hFFFFFF, 24'hFFFFFF, 50, seen);
        check("t3_ack_seen", {31'd0, seen},           32'd1);
        check("t3_ack1_cnt", n_ack1 - b_ack1,         32'd1);
        check("t3_status",   {30'd0, bus.rsp_status}, 32'd2);
        check("t3_result",   bus.rsp_result,          32'd1);
        check("t3_opcnt",    {16'd0, op_count},       32'd5);
        check("t3_dp_a1",    {8'd0, bus.dp_a1},       32'hFFFFFF);

        // ---------------- 4a: timeout ----------------
        set_model(3, 1, 32'hDEAD_BEEF, 6'd24, 1'b1);
        b_abort = n_abort;
        run_job(0, 24'd7, 24'd9, 200, seen);
        check("t4a_ack_seen",  {31'd0, seen},           32'd1);
        check("t4a_status",    {30'd0, bus.rsp_status}, 32'd1);
        check("t4a_result",    bus.rsp_result,          32'd0);
        check("t4a_ones",      {26'd0, bus.rsp_ones},   32'd0);
        check("t4a_opcnt",     {16'd0, op_count},       32'd5);
        check("t4a_abort_cnt", n_abort - b_abort,       32'd1);
        check("t4a_abort_cyc", t_abort - t_ack,         32'd0);
        check("t4a_ack_lat",   t_ack - t_start,         32'd65);
        repeat (3) @(negedge clk);
        check("t4a_abort_once", n_abort - b_abort,      32'd1);

        // ---------------- 4b: done in the final WAIT cycle ----------------
        set_model(64, 0, 32'hA5A5_A5A5, 6'd16, 1'b1);
        b_abort = n_abort;
        run_job(0, 24'd7, 24'd9, 200, seen);
        check("t4b_ack_seen", {31'd0, seen},           32'd1);
        check("t4b_status",   {30'd0, bus.rsp_status}, 32'd3);
        check("t4b_result",   bus.rsp_result,          32'hA5A5_A5A5);
        check("t4b_ones",     {26'd0, bus.rsp_ones},   32'd16);
        check("t4b_no_abort", n_abort - b_abort,       32'd0);
        check("t4b_ack_lat",  t_ack - t_start,         32'd65);
        check("t4b_opcnt",    {16'd0, op_count},       32'd6);

        // ---------------- 5: reset during WAIT ----------------
        set_model(10, 0, 32'h0000_0010, 6'd1, 1'b1);
        @(negedge clk);
        bus.a1_0 = 24'd4;
        bus.a2_0 = 24'd4;
        bus.req0 = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_busy_wait", {31'd0, busy}, 32'd1);
        n_reset  = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        b_ack0 = n_ack0; b_ack1 = n_ack1;
        n_reset = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_late_done_ack", (n_ack0 - b_ack0) + (n_ack1 - b_ack1), 32'd0);
        check("t5_idle_busy",     {31'd0, busy},           32'd0);
        check("t5_idle_status",   {30'd0, bus.rsp_status}, 32'd0);
        set_model(3, 0, 32'd12, 6'd2, 1'b1);
        run_job(0, 24'd2, 24'd6, 50, seen);
        check("t5_ack_seen", {31'd0, seen},           32'd1);
        check("t5_result",   bus.rsp_result,          32'd12);
        check("t5_ones",     {26'd0, bus.rsp_ones},   32'd2);
        check("t5_status",   {30'd0, bus.rsp_status}, 32'd3);
        check("t5_opcnt",    {16'd0, op_count},       32'd1);

        // ---------------- 6: op_count wrap ----------------
        repeat (2) @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        @(negedge clk);
        check("t6_preload", {16'd0, op_count}, 32'h0000_FFFF);
        set_model(2, 0, 32'd1, 6'd1, 1'b1);
        run_job(0, 24'd1, 24'd1, 50, seen);
        check("t6_ack_seen", {31'd0, seen},           32'd1);
        check("t6_status",   {30'd0, bus.rsp_status}, 32'd3);
        check("t6_wrap",     {16'd0, op_count},       32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
